// File: rtl/adder_pipe_sched.sv
// Round-robin front end for a shared fixed-latency 32-bit adder pipeline.
// Tags follow each operation through the adder, and results land in a FIFO that is protected by credits.
module adder_pipe_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [63:0]             pipe_s,
  input  logic [31:0]             pipe_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_sum,
  output logic                    busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INF_W = $clog2(LATENCY + 1);
  localparam int unsigned CRD_W = $clog2(LATENCY + FIFO_DEPTH + 1);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic             found;
  logic             can_issue;
  logic             issue;
  int unsigned      idx;

  logic             tag_v  [LATENCY];
  logic [ID_W-1:0]  tag_id [LATENCY];
  logic [INF_W-1:0] inflight;

  logic [ID_W-1:0]  mem_id  [FIFO_DEPTH];
  logic [31:0]      mem_sum [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // First valid requester at or after rr_ptr, cyclically.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  // Every valid tag in flight and every FIFO entry holds one credit, so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + INF_W'(tag_v[i]);
    end
  end

  assign can_issue = (CRD_W'(inflight) + CRD_W'(fifo_cnt)) < CRD_W'(FIFO_DEPTH);
  assign issue     = found && can_issue && !rst;

  always_comb begin
    req_ready = '0;
    pipe_s    = '0;
    if (issue) begin
      req_ready[grant] = 1'b1;
      pipe_s = {req_a[32*32'(grant) +: 32], req_b[32*32'(grant) +: 32]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (32'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
    end
  end

  // The tag shift register runs alongside the external adder; the last stage lines up with pipe_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= grant;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign push = tag_v[LATENCY-1];
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]  <= tag_id[LATENCY-1];
      mem_sum[wr_ptr] <= pipe_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
    end
  end

  // The head is gated so that an empty FIFO shows zeros rather than stale data.
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr]  : '0;
  assign rsp_sum   = rsp_valid ? mem_sum[rd_ptr] : '0;
  assign busy      = (inflight != '0) || (fifo_cnt != '0);

  assert property (@(posedge clk) disable iff (rst)
                   !(push && !pop && (fifo_cnt == CNT_W'(FIFO_DEPTH))))
    else $error("adder_pipe_sched: result FIFO overflow");

endmodule
